mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq.sv | 133 +++++++++++++
 tb/tb_mul_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - sequential shift-add multiplier for MUL/MULH/MULHSU/MULHU (and RV64 MULW)
`ifndef ALU_MUL
`define ALU_MUL 5'd10
`endif
`ifndef ALU_MULH
`define ALU_MULH 5'd11
`endif
`ifndef ALU_MULHSU
`define ALU_MULHSU 5'd12
`endif
`ifndef ALU_MULHU
`define ALU_MULHU 5'd13
`endif

module mul_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            s_32,
    input  logic [4:0]      opcode,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state, state_nxt;
    logic [2*XLEN-1:0]   mcand, acc, prod;
    logic [XLEN-1:0]     mplier, rd_q, result;
    logic [CW-1:0]       cnt;
    logic                neg_q, sel_hi_q, w32_q;

    logic                w32, is_mul, is_mulh, is_mulhsu, is_mulhu, op_ok, fire;
    logic                a_neg, b_neg;
    logic [XLEN-1:0]     a_op, b_op, a_mag, b_mag;

    // Request decode: word ops only exist on 64-bit builds and only for MUL.
    always_comb begin
        w32       = (XLEN == 64) && s_32;
        is_mul    = (opcode == `ALU_MUL);
        is_mulh   = (opcode == `ALU_MULH);
        is_mulhsu = (opcode == `ALU_MULHSU);
        is_mulhu  = (opcode == `ALU_MULHU);
        op_ok     = (is_mul || is_mulh || is_mulhsu || is_mulhu) && !(w32 && !is_mul);
        fire      = in_valid && (state == IDLE) && !flush;
        a_op      = w32 ? XLEN'($signed(rs1[31:0])) : rs1;
        b_op      = w32 ? XLEN'($signed(rs2[31:0])) : rs2;
        a_neg     = (is_mul || is_mulh || is_mulhsu) && a_op[XLEN-1];
        b_neg     = (is_mul || is_mulh) && b_op[XLEN-1];
        // The most-negative value negates to itself, which is its correct unsigned magnitude.
        a_mag     = a_neg ? -a_op : a_op;
        b_mag     = b_neg ? -b_op : b_op;
    end

    always_comb begin
        prod = neg_q ? -acc : acc;
        if (sel_hi_q)
            result = prod[2*XLEN-1:XLEN];
        else if (w32_q)
            result = XLEN'($signed(prod[31:0]));
        else
            result = prod[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = op_ok ? CALC : DONE;
            CALC: if (cnt == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        rd        = rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            sel_hi_q <= 1'b0;
            w32_q    <= 1'b0;
            rd_q     <= '0;
        end else if (fire) begin
            if (op_ok) begin
                mcand    <= {{XLEN{1'b0}}, a_mag};
                mplier   <= b_mag;
                acc      <= '0;
                cnt      <= w32 ? CW'(32) : CW'(XLEN);
                neg_q    <= a_neg ^ b_neg;
                sel_hi_q <= !is_mul;
                w32_q    <= w32;
            end else begin
                rd_q <= '0;
            end
        end else if (state == CALC && !flush) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end else if (state == FIX && !flush) begin
            rd_q <= result;
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - scoreboard bench for mul_seq at XLEN=32 and XLEN=64
`ifndef ALU_MUL
`define ALU_MUL 5'd10
`endif
`ifndef ALU_MULH
`define ALU_MULH 5'd11
`endif
`ifndef ALU_MULHSU
`define ALU_MULHSU 5'd12
`endif
`ifndef ALU_MULHU
`define ALU_MULHU 5'd13
`endif

module tb_mul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        n_in_valid, n_in_ready, n_s_32, n_flush, n_out_valid, n_out_ready;
    logic [4:0]  n_opcode;
    logic [31:0] n_rs1, n_rs2, n_rd;

    logic        w_in_valid, w_in_ready, w_s_32, w_flush, w_out_valid, w_out_ready;
    logic [4:0]  w_opcode;
    logic [63:0] w_rs1, w_rs2, w_rd;

    mul_seq #(.XLEN(32)) dut_n (
        .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .s_32(n_s_32), .opcode(n_opcode), .rs1(n_rs1), .rs2(n_rs2), .flush(n_flush),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .rd(n_rd)
    );

    mul_seq #(.XLEN(64)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .s_32(w_s_32), .opcode(w_opcode), .rs1(w_rs1), .rs2(w_rs2), .flush(w_flush),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .rd(w_rd)
    );

    typedef struct {
        logic [63:0] rd;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t q_n[$];
    exp_t q_w[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue_n(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_rd, input int lat, input bit push);
        exp_t e;
        int   w;
        @(negedge clk);
        n_opcode = op; n_rs1 = a; n_rs2 = b; n_s_32 = 1'b0; n_in_valid = 1'b1;
        w = 0;
        while (!n_in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!n_in_ready) begin
            checks++; errors++;
            $display("FAIL n_accept_timeout: in_ready=0 expected 1");
            n_in_valid = 1'b0;
            return;
        end
        if (push) begin
            e.rd = {32'd0, exp_rd}; e.lat = lat; e.acc_cyc = cyc;
            q_n.push_back(e);
        end
        @(posedge clk);
        #1;
        n_in_valid = 1'b0; n_rs1 = '1; n_rs2 = '1; n_opcode = 5'd31;
    endtask

    task automatic issue_w(input logic [4:0] op, input logic s32, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp_rd, input int lat);
        exp_t e;
        int   w;
        @(negedge clk);
        w_opcode = op; w_rs1 = a; w_rs2 = b; w_s_32 = s32; w_in_valid = 1'b1;
        w = 0;
        while (!w_in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!w_in_ready) begin
            checks++; errors++;
            $display("FAIL w_accept_timeout: in_ready=0 expected 1");
            w_in_valid = 1'b0;
            return;
        end
        e.rd = exp_rd; e.lat = lat; e.acc_cyc = cyc;
        q_w.push_back(e);
        @(posedge clk);
        #1;
        w_in_valid = 1'b0; w_rs1 = '1; w_rs2 = '1; w_opcode = 5'd31; w_s_32 = ~s32;
    endtask

    logic n_prev_valid = 1'b0;
    int   n_first      = 0;
    always @(negedge clk) begin : mon_n
        exp_t e;
        int   first;
        first = (n_out_valid && !n_prev_valid) ? cyc : n_first;
        n_first      <= first;
        n_prev_valid <= n_out_valid;
        if (n_out_valid && n_out_ready) begin
            if (q_n.size() == 0) begin
                checks++; errors++;
                $display("FAIL n_unexpected_out: out_valid=1 expected 0");
            end else begin
                e = q_n.pop_front();
                check("n_rd", {32'd0, n_rd}, e.rd);
                check("n_latency", 64'(first - e.acc_cyc), 64'(e.lat));
            end
        end
    end

    logic w_prev_valid = 1'b0;
    int   w_first      = 0;
    always @(negedge clk) begin : mon_w
        exp_t e;
        int   first;
        first = (w_out_valid && !w_prev_valid) ? cyc : w_first;
        w_first      <= first;
        w_prev_valid <= w_out_valid;
        if (w_out_valid && w_out_ready) begin
            if (q_w.size() == 0) begin
                checks++; errors++;
                $display("FAIL w_unexpected_out: out_valid=1 expected 0");
            end else begin
                e = q_w.pop_front();
                check("w_rd", w_rd, e.rd);
                check("w_latency", 64'(first - e.acc_cyc), 64'(e.lat));
            end
        end
    end

    initial begin
        int w;
        rst_n = 1'b0;
        n_in_valid = 1'b0; n_s_32 = 1'b0; n_flush = 1'b0; n_out_ready = 1'b1;
        n_opcode = '0; n_rs1 = '0; n_rs2 = '0;
        w_in_valid = 1'b0; w_s_32 = 1'b0; w_flush = 1'b0; w_out_ready = 1'b1;
        w_opcode = '0; w_rs1 = '0; w_rs2 = '0;
        #1;
        check("rst_n_in_ready", {63'd0, n_in_ready}, 64'd1);
        check("rst_n_out_valid", {63'd0, n_out_valid}, 64'd0);
        check("rst_n_rd", {32'd0, n_rd}, 64'd0);
        check("rst_w_in_ready", {63'd0, w_in_ready}, 64'd1);
        check("rst_w_out_valid", {63'd0, w_out_valid}, 64'd0);
        check("rst_w_rd", w_rd, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue_n(`ALU_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b1);
        issue_n(`ALU_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 34, 1'b1);
        issue_n(`ALU_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b1);
        issue_n(`ALU_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 34, 1'b1);
        issue_n(`ALU_MUL,    32'd0,          32'hFFFFFFFF, 32'h00000000, 34, 1'b1);
        issue_n(`ALU_MULH,   32'd0,          32'hFFFFFFFF, 32'h00000000, 34, 1'b1);
        issue_n(`ALU_MULH,   32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 34, 1'b1);
        issue_n(`ALU_MUL,    32'h12345678,   32'h10,       32'h23456780, 34, 1'b1);
        issue_n(5'd31,       32'h12345678,   32'h10,       32'h00000000, 1,  1'b1);

        issue_w(`ALU_MUL,   1'b1, 64'h7FFFFFFF,          64'd2,                  64'hFFFFFFFFFFFFFFFE, 34);
        issue_w(`ALU_MULH,  1'b1, 64'h7FFFFFFF,          64'd2,                  64'h0,                1);
        issue_w(`ALU_MUL,   1'b0, 64'd3,                 64'd5,                  64'd15,               66);
        issue_w(`ALU_MULHU, 1'b0, 64'hFFFFFFFFFFFFFFFF,  64'd2,                  64'd1,                66);
        issue_w(`ALU_MUL,   1'b1, 64'hDEADBEEF00000003,  64'h12345678FFFFFFFF,   64'hFFFFFFFFFFFFFFFD, 34);

        // Backpressure: result must hold while the consumer stalls.
        n_out_ready = 1'b0;
        issue_n(`ALU_MULHU, 32'h80000000, 32'd2, 32'd1, 34, 1'b1);
        w = 0;
        while (!n_out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", {63'd0, n_out_valid}, 64'd1);
            check("bp_rd", {32'd0, n_rd}, 64'd1);
            check("bp_in_ready", {63'd0, n_in_ready}, 64'd0);
        end
        n_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", {63'd0, n_in_ready}, 64'd1);
        check("bp_release_out_valid", {63'd0, n_out_valid}, 64'd0);

        // Flush during the fifth CALC cycle.
        issue_n(`ALU_MUL, 32'd9, 32'd9, 32'd81, 34, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        n_flush = 1'b1;
        @(posedge clk);
        #1;
        n_flush = 1'b0;
        check("flush_in_ready", {63'd0, n_in_ready}, 64'd1);
        check("flush_out_valid", {63'd0, n_out_valid}, 64'd0);
        repeat (40) @(posedge clk);
        issue_n(`ALU_MUL, 32'd3, 32'd5, 32'd15, 34, 1'b1);

        w = 0;
        while ((q_n.size() != 0 || q_w.size() != 0) && w < 300) begin
            @(negedge clk);
            w++;
        end

        // Asynchronous reset in the middle of CALC.
        issue_n(`ALU_MUL, 32'd6, 32'd7, 32'd42, 34, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, n_out_valid}, 64'd0);
        check("midrst_in_ready", {63'd0, n_in_ready}, 64'd1);
        check("midrst_rd", {32'd0, n_rd}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue_n(`ALU_MUL, 32'd2, 32'd2, 32'd4, 34, 1'b1);

        w = 0;
        while ((q_n.size() != 0 || q_w.size() != 0) && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (q_n.size() != 0 || q_w.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: pending=%0d expected 0", q_n.size() + q_w.size());
        end
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
